// File: rtl/i2c_wb_cmd_sequencer_if.sv
// Request/response handshake plus Wishbone master bus of the I2C command sequencer.
interface i2c_wb_cmd_sequencer_if;
  logic       req_valid_i;
  logic       req_ready_o;
  logic       req_rnw_i;
  logic [6:0] req_dev_i;
  logic [7:0] req_reg_i;
  logic [7:0] req_wdata_i;
  logic       rsp_valid_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_nack_o;
  logic       rsp_al_o;
  logic       rsp_tmo_o;
  logic [2:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i;
  logic       wbm_we_o;
  logic       wbm_stb_o;
  logic       wbm_cyc_o;
  logic       wbm_ack_i;

  modport master (
    input  req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_wdata_i, wbm_dat_i, wbm_ack_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o, rsp_al_o, rsp_tmo_o,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );

  modport slave (
    output req_valid_i, req_rnw_i, req_dev_i, req_reg_i, req_wdata_i, wbm_dat_i, wbm_ack_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_nack_o, rsp_al_o, rsp_tmo_o,
           wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_stb_o, wbm_cyc_o
  );
endinterface

// File: rtl/i2c_wb_cmd_sequencer.sv
// Turns single-byte I2C register read/write requests into txr/cr writes and sr/rxr polls
// on the Wishbone port of an I2C master core, returning data plus NACK/AL/timeout status.
module i2c_wb_cmd_sequencer #(
  parameter logic [15:0] POLL_TIMEOUT = 16'd50000,
  parameter int unsigned POLL_GAP     = 4
) (
  input logic               wb_clk_i,
  input logic               arst_ni,
  i2c_wb_cmd_sequencer_if.master bus
);
  typedef enum logic [3:0] {IDLE, TX, CMD, GAP, POLL, EVAL, RDRX, STOP_CMD, STOP_POLL, RESP} state_t;

  typedef struct packed {
    logic       rnw;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wdata;
  } req_t;

  localparam logic [2:0] ADR_TXR = 3'd3, ADR_CR = 3'd4;
  localparam logic [4:0] GAP_LIM = (POLL_GAP == 0) ? 5'd1 : 5'(POLL_GAP);

  state_t      state_q, state_n;
  logic [2:0]  step_q, step_n;
  logic [15:0] poll_q, poll_n;
  logic [3:0]  gap_q, gap_n;
  logic        bus_gap_q, in_stop_q, in_stop_n;
  req_t        req_q, req_n;
  logic [2:0]  sr_q, sr_n;  // {rxack, al, tip}
  logic [7:0]  rdata_q, rdata_n;
  logic        nack_q, nack_n, al_q, al_n, tmo_q, tmo_n;

  logic       access, stb, ack, we;
  logic [2:0] adr;
  logic [7:0] dat, tx_byte, cmd_byte;
  logic       ends_wr, sto_issued, last_step;

  always_comb begin
    case (step_q)
      3'd0:    tx_byte = {req_q.dev, 1'b0};
      3'd1:    tx_byte = req_q.rg;
      default: tx_byte = req_q.rnw ? {req_q.dev, 1'b1} : req_q.wdata;
    endcase
    case (step_q)
      3'd0:    cmd_byte = 8'h90;
      3'd1:    cmd_byte = 8'h10;
      3'd2:    cmd_byte = req_q.rnw ? 8'h90 : 8'h50;
      default: cmd_byte = 8'h68;
    endcase
  end

  assign ends_wr    = !(req_q.rnw && step_q == 3'd3);
  assign sto_issued = !req_q.rnw && step_q == 3'd2;
  assign last_step  = !req_q.rnw && step_q == 3'd2;

  // Bus fields come straight from state; one dead cycle after every ack keeps the slave's
  // cyc&stb&~ack handshake from re-triggering.
  always_comb begin
    access = 1'b0;
    we     = 1'b0;
    adr    = 3'd0;
    dat    = 8'd0;
    case (state_q)
      TX:        begin access = 1'b1; we = 1'b1; adr = ADR_TXR; dat = tx_byte;  end
      CMD:       begin access = 1'b1; we = 1'b1; adr = ADR_CR;  dat = cmd_byte; end
      STOP_CMD:  begin access = 1'b1; we = 1'b1; adr = ADR_CR;  dat = 8'h40;    end
      POLL:      begin access = 1'b1; adr = ADR_CR;  end
      STOP_POLL: begin access = 1'b1; adr = ADR_CR;  end
      RDRX:      begin access = 1'b1; adr = ADR_TXR; end
      default:   ;
    endcase
  end

  assign stb = access & ~bus_gap_q;
  assign ack = stb & bus.wbm_ack_i;

  assign bus.wbm_cyc_o   = stb;
  assign bus.wbm_stb_o   = stb;
  assign bus.wbm_we_o    = stb & we;
  assign bus.wbm_adr_o   = stb ? adr : 3'd0;
  assign bus.wbm_dat_o   = stb ? dat : 8'd0;
  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_nack_o  = nack_q;
  assign bus.rsp_al_o    = al_q;
  assign bus.rsp_tmo_o   = tmo_q;

  always_comb begin
    state_n   = state_q;
    step_n    = step_q;
    poll_n    = poll_q;
    gap_n     = gap_q;
    in_stop_n = in_stop_q;
    req_n     = req_q;
    sr_n      = sr_q;
    rdata_n   = rdata_q;
    nack_n    = nack_q;
    al_n      = al_q;
    tmo_n     = tmo_q;
    case (state_q)
      IDLE: if (bus.req_valid_i) begin
        req_n     = '{rnw: bus.req_rnw_i, dev: bus.req_dev_i, rg: bus.req_reg_i, wdata: bus.req_wdata_i};
        step_n    = 3'd0;
        in_stop_n = 1'b0;
        rdata_n   = 8'd0;
        nack_n    = 1'b0;
        al_n      = 1'b0;
        tmo_n     = 1'b0;
        state_n   = TX;
      end
      TX:  if (ack) state_n = CMD;
      CMD: if (ack) begin poll_n = 16'd0; gap_n = 4'd0; state_n = GAP; end
      GAP: if ({1'b0, gap_q} + 5'd1 >= GAP_LIM) begin
        gap_n   = 4'd0;
        state_n = in_stop_q ? STOP_POLL : POLL;
      end else gap_n = gap_q + 4'd1;
      POLL: if (ack) begin
        sr_n    = {bus.wbm_dat_i[7], bus.wbm_dat_i[5], bus.wbm_dat_i[1]};
        poll_n  = poll_q + 16'd1;
        state_n = EVAL;
      end
      EVAL:
        if (sr_q[0]) begin
          if (poll_q >= POLL_TIMEOUT) begin tmo_n = 1'b1; state_n = STOP_CMD; end
          else state_n = GAP;
        end else if (sr_q[1]) begin
          al_n    = 1'b1;
          state_n = RESP;
        end else if (ends_wr && sr_q[2]) begin
          nack_n  = 1'b1;
          state_n = sto_issued ? RESP : STOP_CMD;
        end else if (last_step) state_n = RESP;
        else if (req_q.rnw && step_q == 3'd3) state_n = RDRX;
        else begin
          step_n  = step_q + 3'd1;
          // the NACK-read byte has no txr load, only a command
          state_n = (req_q.rnw && step_q == 3'd2) ? CMD : TX;
        end
      RDRX: if (ack) begin rdata_n = bus.wbm_dat_i; state_n = RESP; end
      STOP_CMD: if (ack) begin
        poll_n    = 16'd0;
        gap_n     = 4'd0;
        in_stop_n = 1'b1;
        state_n   = GAP;
      end
      STOP_POLL: if (ack) begin
        poll_n = poll_q + 16'd1;
        if (!bus.wbm_dat_i[6]) state_n = RESP;
        else if (poll_q + 16'd1 >= POLL_TIMEOUT) begin tmo_n = 1'b1; state_n = RESP; end
        else state_n = GAP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      poll_q    <= 16'd0;
      gap_q     <= 4'd0;
      bus_gap_q <= 1'b0;
      in_stop_q <= 1'b0;
      req_q     <= '0;
      sr_q      <= 3'd0;
      rdata_q   <= 8'd0;
      nack_q    <= 1'b0;
      al_q      <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      step_q    <= step_n;
      poll_q    <= poll_n;
      gap_q     <= gap_n;
      bus_gap_q <= ack;
      in_stop_q <= in_stop_n;
      req_q     <= req_n;
      sr_q      <= sr_n;
      rdata_q   <= rdata_n;
      nack_q    <= nack_n;
      al_q      <= al_n;
      tmo_q     <= tmo_n;
    end
  end
endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// Self-checking bench: behavioural I2C-master register model on the Wishbone side,
// scoreboard queues of expected bus writes and responses.
module tb_i2c_wb_cmd_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_wb_cmd_sequencer_if bus();

  i2c_wb_cmd_sequencer #(.POLL_TIMEOUT(16'd8), .POLL_GAP(2)) dut (
    .wb_clk_i(clk),
    .arst_ni (rst_n),
    .bus     (bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // scenario knobs
  logic       cfg_nack, cfg_tip_stuck;
  int         cfg_al_cmd;
  logic [7:0] cfg_rx;

  // register model of the I2C master
  logic       ack, busy, al, rxack, sto_pend;
  logic [3:0] tip_cnt;
  int         cmd_no;
  logic       tip;

  assign tip           = cfg_tip_stuck || (tip_cnt != 0 && !al);
  assign bus.wbm_ack_i = ack;
  assign bus.wbm_dat_i = (bus.wbm_adr_o == 3'd4) ? {rxack, busy, al, 3'b000, tip, 1'b0} :
                         (bus.wbm_adr_o == 3'd3) ? cfg_rx : 8'h00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack <= 1'b0; busy <= 1'b0; al <= 1'b0; rxack <= 1'b0; sto_pend <= 1'b0;
      tip_cnt <= 4'd0; cmd_no <= 0;
    end else begin
      ack <= bus.wbm_cyc_o & bus.wbm_stb_o & ~ack;
      if (bus.wbm_cyc_o & bus.wbm_stb_o & ack & (bus.wbm_adr_o == 3'd4)) begin
        if (bus.wbm_we_o) begin
          cmd_no   <= cmd_no + 1;
          tip_cnt  <= 4'd2;
          sto_pend <= bus.wbm_dat_o[6];
          rxack    <= cfg_nack;
          al       <= (cmd_no == cfg_al_cmd);
          if (bus.wbm_dat_o[7]) busy <= 1'b1;
        end else if (tip_cnt != 0) tip_cnt <= tip_cnt - 4'd1;
        else if (sto_pend) begin busy <= 1'b0; sto_pend <= 1'b0; end
      end
    end
  end

  // scoreboard
  logic [10:0] exp_wr[$];
  logic [10:0] exp_rsp[$];
  logic [10:0] e;
  int cyc_n = 0, cmd_cyc = 0, polls = 0, last_polls = 0, rx_reads = 0;
  logic ack_prev = 1'b0;

  always @(negedge clk) begin
    cyc_n++;
    if (ack_prev) chk("bus_idle_after_ack", 32'(bus.wbm_stb_o), 0);
    ack_prev = bus.wbm_cyc_o & bus.wbm_stb_o & ack;
    if (ack_prev) begin
      if (bus.wbm_we_o) begin
        chk("wr_pending", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_adr_dat", {21'd0, bus.wbm_adr_o, bus.wbm_dat_o}, {21'd0, e});
        end
        if (bus.wbm_adr_o == 3'd4) begin last_polls = polls; polls = 0; cmd_cyc = cyc_n; end
      end else if (bus.wbm_adr_o == 3'd4) begin
        if (polls == 0) chk("first_poll_gap", 32'(cyc_n - cmd_cyc >= 3), 1);
        polls++;
      end else if (bus.wbm_adr_o == 3'd3) rx_reads++;
    end
    if (bus.rsp_valid_o) begin
      chk("rsp_pending", 32'(exp_rsp.size() != 0), 1);
      if (exp_rsp.size() != 0) begin
        e = exp_rsp.pop_front();
        chk("rsp_fields", {21'd0, bus.rsp_rdata_o, bus.rsp_nack_o, bus.rsp_al_o, bus.rsp_tmo_o}, {21'd0, e});
      end
    end
  end

  task automatic exp_w(input logic [2:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cfg_nack = 1'b0; cfg_tip_stuck = 1'b0; cfg_al_cmd = -1; cfg_rx = 8'h00;
    exp_wr.delete(); exp_rsp.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic rnw, input logic [6:0] dev, input logic [7:0] rg, input logic [7:0] wd);
    @(negedge clk);
    chk("ready_before_req", 32'(bus.req_ready_o), 1);
    bus.req_valid_i = 1'b1; bus.req_rnw_i = rnw; bus.req_dev_i = dev;
    bus.req_reg_i = rg; bus.req_wdata_i = wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0; bus.req_rnw_i = 1'b0; bus.req_dev_i = 7'd0;
    bus.req_reg_i = 8'd0; bus.req_wdata_i = 8'd0;
    chk("ready_low_busy", 32'(bus.req_ready_o), 0);
  endtask

  task automatic wait_rsp(input logic [10:0] ex);
    logic seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = bus.rsp_valid_o;
    end
    chk("rsp_seen", 32'(seen), 1);
    @(negedge clk);
    chk("ready_after_rsp", 32'(bus.req_ready_o), 1);
    repeat (2) @(negedge clk);
    chk("rsp_hold", {21'd0, bus.rsp_rdata_o, bus.rsp_nack_o, bus.rsp_al_o, bus.rsp_tmo_o}, {21'd0, ex});
    chk("wr_left", 32'(exp_wr.size()), 0);
  endtask

  task automatic run_write_ok();
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(3, 8'h12); exp_w(4, 8'h10); exp_w(3, 8'hA5); exp_w(4, 8'h50);
    exp_rsp.push_back({8'h00, 3'b000});
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp({8'h00, 3'b000});
  endtask

  initial begin
    int rx0;
    logic up;
    rst_n = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_rnw_i = 1'b0; bus.req_dev_i = 7'd0;
    bus.req_reg_i = 8'd0; bus.req_wdata_i = 8'd0;
    do_reset();

    chk("rst_ready", 32'(bus.req_ready_o), 1);
    chk("rst_valid", 32'(bus.rsp_valid_o), 0);
    chk("rst_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    chk("rst_rsp", {21'd0, bus.rsp_rdata_o, bus.rsp_nack_o, bus.rsp_al_o, bus.rsp_tmo_o}, 0);

    // plain write, slave ACKs everything
    run_write_ok();

    // read returning 0x3C
    cfg_rx = 8'h3C;
    rx0 = rx_reads;
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(3, 8'h07); exp_w(4, 8'h10);
    exp_w(3, 8'hA1); exp_w(4, 8'h90); exp_w(4, 8'h68);
    exp_rsp.push_back({8'h3C, 3'b000});
    send(1'b1, 7'h50, 8'h07, 8'h00);
    wait_rsp({8'h3C, 3'b000});
    chk("rxr_reads", 32'(rx_reads - rx0), 1);

    // absent slave: NACK on the address byte, STOP, no more txr writes
    do_reset();
    cfg_nack = 1'b1;
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(4, 8'h40);
    exp_rsp.push_back({8'h00, 3'b100});
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp({8'h00, 3'b100});

    // arbitration lost during step 2: no STOP
    do_reset();
    cfg_al_cmd = 1;
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(3, 8'h12); exp_w(4, 8'h10);
    exp_rsp.push_back({8'h00, 3'b010});
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp({8'h00, 3'b010});

    // TIP stuck: 8 polls, STOP, timeout flag
    do_reset();
    cfg_tip_stuck = 1'b1;
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(4, 8'h40);
    exp_rsp.push_back({8'h00, 3'b001});
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    wait_rsp({8'h00, 3'b001});
    chk("tip_polls", 32'(last_polls), 8);

    // reset during the step-2 wait
    do_reset();
    exp_w(3, 8'hA0); exp_w(4, 8'h90); exp_w(3, 8'h12); exp_w(4, 8'h10);
    send(1'b0, 7'h50, 8'h12, 8'hA5);
    for (int i = 0; i < 200 && exp_wr.size() != 0; i++) @(negedge clk);
    chk("reached_step2_wait", 32'(exp_wr.size()), 0);
    up = 1'b0;
    for (int i = 0; i < 50 && !up; i++) begin @(negedge clk); up = bus.wbm_cyc_o; end
    chk("poll_active", 32'(up), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cyc_stb", {30'd0, bus.wbm_cyc_o, bus.wbm_stb_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", 32'(bus.req_ready_o), 1);
    run_write_ok();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
